// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/write-back,
// with memory wait states, a retired-instruction counter and a sticky illegal-instruction trap.
module mips_multicycle_ctrl #(
  parameter int ALU_CTRL_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  iszero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  PCWriteCond,
  output logic                  IorD,
  output logic                  IRWrite,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  MemToReg,
  output logic                  RegDst,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            PCSrc,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            state,
  output logic                  illegal,
  output logic [CNT_W-1:0]      retired
);

  // Memory handshake: mem_ready high in FETCH, MEMRD or MEMWR means the access
  // completes at the next rising edge; while it is low the FSM holds its state.

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       funct_ok;
  logic       retire;

  // The branch-taken decision is made in the datapath, so the zero flag and the
  // register/immediate fields of instr are not needed here.
  logic unused_inputs;
  assign unused_inputs = ^{iszero, instr[25:6]};

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                               funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_TRAP;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // Moore outputs; only IRWrite/PCWrite in FETCH look at mem_ready. Everything
  // is held low while reset is asserted so an aborted access never writes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    alu_control = ALU_ADD;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          MemToReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          case (funct)
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: alu_control = ALU_ADD;
          endcase
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          alu_control = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSrc       = 2'b01;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl: per-cycle vectors of expected
// state/strobes/counter, plus hand-written trap and mid-instruction reset sequences.
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        iszero;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic        MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [4:0]  alu_control;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;

  mips_multicycle_ctrl #(.ALU_CTRL_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .iszero(iszero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .alu_control(alu_control), .state(state), .illegal(illegal), .retired(retired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bundle order: pcw pcwc iord irw mr mw mtr rd rw asa asb[1:0] pcs[1:0]
  logic [13:0] dut_ctl;
  assign dut_ctl = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
                    MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSrc};

  localparam logic [13:0] C_ZERO   = 14'b0_0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [13:0] C_FETCH1 = 14'b1_0_0_1_1_0_0_0_0_0_01_00;
  localparam logic [13:0] C_FETCH0 = 14'b0_0_0_0_1_0_0_0_0_0_01_00;
  localparam logic [13:0] C_DECODE = 14'b0_0_0_0_0_0_0_0_0_0_11_00;
  localparam logic [13:0] C_MEMADR = 14'b0_0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [13:0] C_MEMRD  = 14'b0_0_1_0_1_0_0_0_0_0_00_00;
  localparam logic [13:0] C_MEMWB  = 14'b0_0_0_0_0_0_1_0_1_0_00_00;
  localparam logic [13:0] C_MEMWR  = 14'b0_0_1_0_0_1_0_0_0_0_00_00;
  localparam logic [13:0] C_EXEC   = 14'b0_0_0_0_0_0_0_0_0_1_00_00;
  localparam logic [13:0] C_ALUWB  = 14'b0_0_0_0_0_0_0_1_1_0_00_00;
  localparam logic [13:0] C_BRANCH = 14'b0_1_0_0_0_0_0_0_0_1_00_01;
  localparam logic [13:0] C_ADDIEX = 14'b0_0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [13:0] C_ADDIWB = 14'b0_0_0_0_0_0_0_0_1_0_00_00;
  localparam logic [13:0] C_JUMP   = 14'b1_0_0_0_0_0_0_0_0_0_00_10;

  localparam logic [31:0] I_ADD  = 32'h0043_0820;
  localparam logic [31:0] I_SUB  = 32'h0043_0822;
  localparam logic [31:0] I_AND  = 32'h0043_0824;
  localparam logic [31:0] I_OR   = 32'h0043_0825;
  localparam logic [31:0] I_SLT  = 32'h0043_082A;
  localparam logic [31:0] I_LW   = 32'h8C41_0000;
  localparam logic [31:0] I_SW   = 32'hAC41_0000;
  localparam logic [31:0] I_BEQ  = 32'h1043_0003;
  localparam logic [31:0] I_ADDI = 32'h2041_0005;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_BADOP = 32'hFC00_0000;
  localparam logic [31:0] I_BADFN = 32'h0043_0801;

  typedef struct {
    logic [31:0] instr;
    logic        mr;
    logic [3:0]  st;
    logic [13:0] ctl;
    logic [4:0]  alu;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic [31:0] i, logic m, logic [3:0] s, logic [13:0] c,
                               logic [4:0] a, logic [31:0] r);
    vec_t v;
    v.instr = i; v.mr = m; v.st = s; v.ctl = c; v.alu = a; v.ret = r;
    return v;
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs on the falling edge, sample 1ns later
  task automatic step(input logic [31:0] i, input logic m);
    @(negedge clk);
    instr = i;
    mem_ready = m;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'(dut_ctl), 32'(C_ZERO));
    chk("rst_retired", retired, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    instr = 32'h0;
    iszero = 1'b0;
    mem_ready = 1'b0;

    // add, lw (2 wait states), sw (fetch + store wait), beq, addi, j, sub/and/or/slt
    vecs.push_back(mkv(I_ADD, 1, 0, C_FETCH1, 0, 0));
    vecs.push_back(mkv(I_ADD, 1, 1, C_DECODE, 0, 0));
    vecs.push_back(mkv(I_ADD, 1, 6, C_EXEC,   0, 0));
    vecs.push_back(mkv(I_ADD, 1, 7, C_ALUWB,  0, 0));
    vecs.push_back(mkv(I_LW,  1, 0, C_FETCH1, 0, 1));
    vecs.push_back(mkv(I_LW,  1, 1, C_DECODE, 0, 1));
    vecs.push_back(mkv(I_LW,  1, 2, C_MEMADR, 0, 1));
    vecs.push_back(mkv(I_LW,  0, 3, C_MEMRD,  0, 1));
    vecs.push_back(mkv(I_LW,  0, 3, C_MEMRD,  0, 1));
    vecs.push_back(mkv(I_LW,  1, 3, C_MEMRD,  0, 1));
    vecs.push_back(mkv(I_LW,  1, 4, C_MEMWB,  0, 1));
    vecs.push_back(mkv(I_SW,  0, 0, C_FETCH0, 0, 2));
    vecs.push_back(mkv(I_SW,  1, 0, C_FETCH1, 0, 2));
    vecs.push_back(mkv(I_SW,  1, 1, C_DECODE, 0, 2));
    vecs.push_back(mkv(I_SW,  1, 2, C_MEMADR, 0, 2));
    vecs.push_back(mkv(I_SW,  0, 5, C_MEMWR,  0, 2));
    vecs.push_back(mkv(I_SW,  1, 5, C_MEMWR,  0, 2));
    vecs.push_back(mkv(I_BEQ, 1, 0, C_FETCH1, 0, 3));
    vecs.push_back(mkv(I_BEQ, 1, 1, C_DECODE, 0, 3));
    vecs.push_back(mkv(I_BEQ, 1, 8, C_BRANCH, 1, 3));
    vecs.push_back(mkv(I_ADDI, 1, 0, C_FETCH1, 0, 4));
    vecs.push_back(mkv(I_ADDI, 1, 1, C_DECODE, 0, 4));
    vecs.push_back(mkv(I_ADDI, 1, 9, C_ADDIEX, 0, 4));
    vecs.push_back(mkv(I_ADDI, 1, 10, C_ADDIWB, 0, 4));
    vecs.push_back(mkv(I_J,   1, 0, C_FETCH1, 0, 5));
    vecs.push_back(mkv(I_J,   1, 1, C_DECODE, 0, 5));
    vecs.push_back(mkv(I_J,   1, 11, C_JUMP,  0, 5));
    vecs.push_back(mkv(I_SUB, 1, 0, C_FETCH1, 0, 6));
    vecs.push_back(mkv(I_SUB, 1, 1, C_DECODE, 0, 6));
    vecs.push_back(mkv(I_SUB, 1, 6, C_EXEC,   1, 6));
    vecs.push_back(mkv(I_SUB, 1, 7, C_ALUWB,  0, 6));
    vecs.push_back(mkv(I_AND, 1, 0, C_FETCH1, 0, 7));
    vecs.push_back(mkv(I_AND, 1, 1, C_DECODE, 0, 7));
    vecs.push_back(mkv(I_AND, 1, 6, C_EXEC,   2, 7));
    vecs.push_back(mkv(I_AND, 1, 7, C_ALUWB,  0, 7));
    vecs.push_back(mkv(I_OR,  1, 0, C_FETCH1, 0, 8));
    vecs.push_back(mkv(I_OR,  1, 1, C_DECODE, 0, 8));
    vecs.push_back(mkv(I_OR,  1, 6, C_EXEC,   3, 8));
    vecs.push_back(mkv(I_OR,  1, 7, C_ALUWB,  0, 8));
    vecs.push_back(mkv(I_SLT, 1, 0, C_FETCH1, 0, 9));
    vecs.push_back(mkv(I_SLT, 1, 1, C_DECODE, 0, 9));
    vecs.push_back(mkv(I_SLT, 1, 6, C_EXEC,   4, 9));
    vecs.push_back(mkv(I_SLT, 1, 7, C_ALUWB,  0, 9));
    vecs.push_back(mkv(I_ADD, 0, 0, C_FETCH0, 0, 10));

    reset_dut();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].instr, vecs[i].mr);
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d_ctl", i), 32'(dut_ctl), 32'(vecs[i].ctl));
      chk($sformatf("v%0d_alu", i), 32'(alu_control), 32'(vecs[i].alu));
      chk($sformatf("v%0d_retired", i), retired, vecs[i].ret);
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'd0);
    end

    // illegal opcode, then unsupported R-type funct: sticky trap until reset
    for (int t = 0; t < 2; t++) begin
      logic [31:0] bad;
      bad = (t == 0) ? I_BADOP : I_BADFN;
      reset_dut();
      step(bad, 1);
      chk("trap_fetch", 32'(state), 32'd0);
      step(bad, 1);
      chk("trap_decode", 32'(state), 32'd1);
      for (int c = 0; c < 12; c++) begin
        step(bad, (c % 2) == 0);
        chk($sformatf("trap%0d_state_c%0d", t, c), 32'(state), 32'd12);
        chk($sformatf("trap%0d_illegal_c%0d", t, c), 32'(illegal), 32'd1);
        chk($sformatf("trap%0d_ctl_c%0d", t, c), 32'(dut_ctl), 32'(C_ZERO));
        chk($sformatf("trap%0d_retired_c%0d", t, c), retired, 32'd0);
      end
    end

    // asynchronous reset in the middle of a load wait state
    reset_dut();
    step(I_ADD, 1); step(I_ADD, 1); step(I_ADD, 1); step(I_ADD, 1);
    step(I_LW, 1);  step(I_LW, 1);  step(I_LW, 1);
    step(I_LW, 0);
    chk("abort_pre_state", 32'(state), 32'd3);
    chk("abort_pre_memread", 32'(MemRead), 32'd1);
    chk("abort_pre_retired", retired, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_memread", 32'(MemRead), 32'd0);
    chk("abort_ctl", 32'(dut_ctl), 32'(C_ZERO));
    chk("abort_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(I_ADD, 1);
    chk("resume_state", 32'(state), 32'd0);
    chk("resume_ctl", 32'(dut_ctl), 32'(C_FETCH1));
    step(I_ADD, 1);
    chk("resume_decode", 32'(state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
